// File: rtl/calib_slave_fsm_pkg.sv
// Shared types for the slave-side AIB calibration sequencer.
package calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE              = 3'd0,
    ST_RESET             = 3'd1,
    ST_CONF_DONE         = 3'd2,
    ST_ASSERT_READY      = 3'd3,
    ST_SEND_DLL_LOCK_REQ = 3'd4,
    ST_WAIT_TRANSFER_EN  = 3'd5,
    ST_DONE              = 3'd6,
    ST_FAIL              = 3'd7
  } calib_state_t;

  // Widest channel vector supported; slice with a width cast to get an all-ones mask.
  localparam int unsigned           CHNL_VEC_MAX  = 64;
  localparam logic [CHNL_VEC_MAX-1:0] CHNL_ALL_ONES = '1;

endpackage

// File: rtl/calib_slave_fsm_if.sv
// Control/status bundle between the MAC bridge (master) and the calibration sequencer (slave).
interface calib_slave_fsm_if #(
  parameter int unsigned TOTAL_CHNL_NUM = 24,
  parameter int unsigned MAX_RETRY      = 3
);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  logic                      calib_en;
  logic [TOTAL_CHNL_NUM-1:0] chnl_mask;
  logic [TOTAL_CHNL_NUM-1:0] ms_tx_transfer_en;
  logic [TOTAL_CHNL_NUM-1:0] ms_rx_transfer_en;
  logic                      i_conf_done;
  logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy;
  logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn;
  logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req;
  logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req;
  logic                      calib_done;
  logic                      calib_fail;
  logic                      link_lost;
  logic [RW-1:0]             retry_cnt;

  modport master (
    output calib_en, chnl_mask, ms_tx_transfer_en, ms_rx_transfer_en,
    input  i_conf_done, ns_mac_rdy, ns_adapter_rstn, sl_rx_dcc_dll_lock_req,
           sl_tx_dcc_dll_lock_req, calib_done, calib_fail, link_lost, retry_cnt
  );

  modport slave (
    input  calib_en, chnl_mask, ms_tx_transfer_en, ms_rx_transfer_en,
    output i_conf_done, ns_mac_rdy, ns_adapter_rstn, sl_rx_dcc_dll_lock_req,
           sl_tx_dcc_dll_lock_req, calib_done, calib_fail, link_lost, retry_cnt
  );
endinterface

// File: rtl/calib_slave_fsm_counter.sv
// Loadable, clearable up-counter with a combinational terminal-count compare.
module calib_cycle_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_c_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (clr_i)   cnt_q <= '0;
    else if (load_i)  cnt_q <= load_val_i;
    else if (en_i)    cnt_q <= cnt_q + CNT_W'(1);
  end

  assign tc_c_o = (cnt_q == tc_val_i);
endmodule

// File: rtl/calib_slave_fsm.sv
// Slave-side AIB calibration sequencer: reset hold, config/ready/lock-request ramp,
// bounded wait for master transfer enables with retry, sticky fail and link-loss recovery.
module calib_slave_fsm
  import calib_pkg::*;
#(
  parameter int unsigned TOTAL_CHNL_NUM = 24,
  parameter int unsigned RSTN_HOLD      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  calib_slave_fsm_if.slave bus
);
  localparam int unsigned N        = TOTAL_CHNL_NUM;
  localparam int unsigned RW       = $clog2(MAX_RETRY + 1);
  localparam int unsigned HOLD_MAX = (RSTN_HOLD > TIMEOUT_CYCLES) ? RSTN_HOLD : TIMEOUT_CYCLES;
  localparam int unsigned CW       = $clog2(HOLD_MAX + 1);

  calib_state_t  state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW:0]   retry_inc;
  logic          conf_q, conf_d;
  logic [N-1:0]  rdy_q, rdy_d;
  logic [N-1:0]  lock_q, lock_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          lost_q, lost_d;
  logic          ok, tc, cnt_clr, cnt_en;
  logic [CW-1:0] tc_val;

  assign ok = ((bus.ms_tx_transfer_en & mask_q) == mask_q) &&
              ((bus.ms_rx_transfer_en & mask_q) == mask_q);
  assign retry_inc = {1'b0, retry_q} + (RW+1)'(1);

  // One counter serves both the reset hold and the wait timeout; it restarts on every state change.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == ST_RESET) || (state_q == ST_WAIT_TRANSFER_EN);
  assign tc_val  = (state_q == ST_RESET) ? CW'(RSTN_HOLD - 1) : CW'(TIMEOUT_CYCLES - 1);

  calib_cycle_counter #(.CNT_W(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .tc_val_i   (tc_val),
    .tc_c_o     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      retry_q <= '0;
      conf_q  <= 1'b0;
      rdy_q   <= '0;
      lock_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      conf_q  <= conf_d;
      rdy_q   <= rdy_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    conf_d  = 1'b0;
    rdy_d   = '0;
    lock_d  = '0;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.chnl_mask) begin
          state_d = ST_RESET;
          mask_d  = bus.chnl_mask;
        end
      end
      ST_RESET:             if (tc) state_d = ST_CONF_DONE;
      ST_CONF_DONE:         state_d = ST_ASSERT_READY;
      ST_ASSERT_READY:      state_d = ST_SEND_DLL_LOCK_REQ;
      ST_SEND_DLL_LOCK_REQ: state_d = ST_WAIT_TRANSFER_EN;
      ST_WAIT_TRANSFER_EN: begin
        if (ok) begin
          state_d = ST_DONE;
          retry_d = '0;
        end else if (tc) begin
          retry_d = retry_inc[RW-1:0];
          state_d = (retry_inc == (RW+1)'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
        end
      end
      ST_DONE: begin
        if (!ok) begin
          state_d = ST_RESET;
          retry_d = '0;
          lost_d  = 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    // Dropping calib_en overrides everything, including a pending link-loss pulse.
    if (!bus.calib_en) begin
      state_d = ST_IDLE;
      mask_d  = mask_q;
      lost_d  = 1'b0;
    end
    if (state_d == ST_IDLE) retry_d = '0;

    case (state_d)
      ST_CONF_DONE: conf_d = 1'b1;
      ST_ASSERT_READY: begin
        conf_d = 1'b1;
        rdy_d  = mask_q;
      end
      ST_SEND_DLL_LOCK_REQ, ST_WAIT_TRANSFER_EN: begin
        conf_d = 1'b1;
        rdy_d  = mask_q;
        lock_d = mask_q;
      end
      ST_DONE: begin
        conf_d = 1'b1;
        rdy_d  = mask_q;
        lock_d = mask_q;
        done_d = 1'b1;
      end
      ST_FAIL: fail_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.i_conf_done            = conf_q;
  assign bus.ns_mac_rdy             = rdy_q;
  assign bus.ns_adapter_rstn        = rdy_q;
  assign bus.sl_rx_dcc_dll_lock_req = lock_q;
  assign bus.sl_tx_dcc_dll_lock_req = lock_q;
  assign bus.calib_done             = done_q;
  assign bus.calib_fail             = fail_q;
  assign bus.link_lost              = lost_q;
  assign bus.retry_cnt              = retry_q;
endmodule
